// File: rtl/counter48_rf_access.sv
// counter48_rf_access
// Register-file accessor for a counter wider than the register data bus.
// Reads of word 0 snapshot the whole counter so that subsequent upper-word
// reads return a coherent value. Upper-word writes are staged and committed
// together with the word-0 write as a single-cycle load request.
module counter48_rf_access #(
   parameter int DATASIZE = 48,
   parameter int WORDSIZE = 16
) (
   input  logic                clk,
   input  logic                res,
   input  logic [1:0]          rf_address,
   input  logic                rf_read_en,
   input  logic                rf_write_en,
   input  logic [WORDSIZE-1:0] rf_write_data,
   output logic [WORDSIZE-1:0] rf_read_data,
   output logic                rf_access_complete,
   output logic                rf_invalid_address,
   input  logic [DATASIZE-1:0] counter_value,
   output logic [DATASIZE-1:0] counter_load,
   output logic                counter_load_enable
);

   localparam int         NWORDS   = (DATASIZE + WORDSIZE - 1) / WORDSIZE;
   localparam logic [2:0] NWORDS_L = 3'(NWORDS);

   // Snapshot of the full counter, taken on a word-0 read.
   logic [DATASIZE-1:0] snap;
   // Staged upper words (index 1..3) with their valid flags.
   logic [WORDSIZE-1:0] stage [1:3];
   logic [3:1]          sv;

   logic                addr_valid;
   logic                strobe;
   logic [WORDSIZE-1:0] live_low;
   logic [WORDSIZE-1:0] snap_word [1:3];
   logic [DATASIZE-1:0] load_next;

   assign addr_valid = ({1'b0, rf_address} < NWORDS_L);
   assign strobe     = rf_read_en | rf_write_en;

   // Low word of the live counter, zero-filled when the counter is narrower than a word.
   always_comb begin
      live_low = '0;
      for (int unsigned j = 0; j < WORDSIZE; j++) begin
         if (j < DATASIZE) live_low[j] = counter_value[j];
      end
   end

   // Upper words of the snapshot; bits at or above DATASIZE read as zero.
   always_comb begin
      for (int unsigned w = 1; w < 4; w++) begin
         snap_word[w] = '0;
         for (int unsigned j = 0; j < WORDSIZE; j++) begin
            if (w * WORDSIZE + j < DATASIZE) snap_word[w][j] = snap[w * WORDSIZE + j];
         end
      end
   end

   // Commit value: word 0 from the bus, upper words from staging or the live counter.
   // Built bit by bit so that bits beyond DATASIZE are simply never produced.
   always_comb begin
      load_next = '0;
      for (int unsigned b = 0; b < DATASIZE; b++) begin
         if (b < WORDSIZE) begin
            load_next[b] = rf_write_data[b % WORDSIZE];
         end else if (sv[b / WORDSIZE]) begin
            load_next[b] = stage[b / WORDSIZE][b % WORDSIZE];
         end else begin
            load_next[b] = counter_value[b];
         end
      end
   end

   // Access handling: one completion per strobe, writes win over reads.
   always_ff @(posedge clk) begin
      if (res) begin
         snap                <= '0;
         sv                  <= '0;
         for (int unsigned w = 1; w < 4; w++) stage[w] <= '0;
         counter_load        <= '0;
         counter_load_enable <= 1'b0;
         rf_read_data        <= '0;
         rf_access_complete  <= 1'b0;
         rf_invalid_address  <= 1'b0;
      end else begin
         rf_access_complete  <= strobe;
         rf_invalid_address  <= 1'b0;
         counter_load_enable <= 1'b0;
         if (strobe) begin
            if (!addr_valid) begin
               rf_invalid_address <= 1'b1;
               rf_read_data       <= '0;
            end else if (rf_write_en) begin
               if (rf_address == 2'd0) begin
                  counter_load        <= load_next;
                  counter_load_enable <= 1'b1;
                  sv                  <= '0;
               end else begin
                  stage[rf_address] <= rf_write_data;
                  sv[rf_address]    <= 1'b1;
               end
            end else begin
               if (rf_address == 2'd0) begin
                  snap         <= counter_value;
                  rf_read_data <= live_low;
               end else begin
                  rf_read_data <= snap_word[rf_address];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_counter48_rf_access.sv
// Testbench for counter48_rf_access: a 48-bit and a 40-bit instance share the
// same strobes; both are compared every cycle against an arithmetic model,
// and the 48-bit instance additionally against a table of fixed expectations.
module tb_counter48_rf_access;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic [1:0]  rf_address = '0;
   logic        rf_read_en = 1'b0;
   logic        rf_write_en = 1'b0;
   logic [15:0] rf_write_data = '0;
   logic [47:0] cv48 = '0;
   logic [39:0] cv40 = '0;

   logic [15:0] rd48, rd40;
   logic        cmp48, cmp40, inv48, inv40, le48, le40;
   logic [47:0] load48;
   logic [39:0] load40;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   counter48_rf_access #(.DATASIZE(48), .WORDSIZE(16)) dut48 (
      .clk(clk), .res(res), .rf_address(rf_address), .rf_read_en(rf_read_en),
      .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
      .rf_read_data(rd48), .rf_access_complete(cmp48), .rf_invalid_address(inv48),
      .counter_value(cv48), .counter_load(load48), .counter_load_enable(le48));

   counter48_rf_access #(.DATASIZE(40), .WORDSIZE(16)) dut40 (
      .clk(clk), .res(res), .rf_address(rf_address), .rf_read_en(rf_read_en),
      .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
      .rf_read_data(rd40), .rf_access_complete(cmp40), .rf_invalid_address(inv40),
      .counter_value(cv40), .counter_load(load40), .counter_load_enable(le40));

   // Reference model state per instance (0: 48-bit, 1: 40-bit).
   logic [63:0] m_snap [2];
   logic [63:0] m_load [2];
   logic [15:0] m_stage [2][4];
   bit          m_sv [2][4];
   logic [15:0] m_rd [2];
   bit          m_cmp [2];
   bit          m_inv [2];
   bit          m_le [2];

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_step(int i, bit r, bit rd, bit wr, logic [1:0] a,
                             logic [15:0] wd, logic [47:0] cv);
      int          dsz = (i == 0) ? 48 : 40;
      int          nw  = (dsz + 15) / 16;
      logic [63:0] mask = (64'd1 << dsz) - 64'd1;
      logic [63:0] cvm  = {16'h0, cv} & mask;
      logic [63:0] val;
      logic [63:0] w;
      m_cmp[i] = 0;
      m_inv[i] = 0;
      m_le[i]  = 0;
      if (r) begin
         m_snap[i] = '0;
         m_load[i] = '0;
         m_rd[i]   = '0;
         for (int k = 0; k < 4; k++) begin
            m_stage[i][k] = '0;
            m_sv[i][k]    = 0;
         end
      end else if (rd || wr) begin
         m_cmp[i] = 1;
         if (int'(a) >= nw) begin
            m_inv[i] = 1;
            m_rd[i]  = '0;
         end else if (wr) begin
            if (a == 2'd0) begin
               val = {48'h0, wd};
               for (int k = 1; k < nw; k++) begin
                  w   = m_sv[i][k] ? {48'h0, m_stage[i][k]} : ((cvm >> (16 * k)) & 64'hFFFF);
                  val = val | (w << (16 * k));
               end
               m_load[i] = val & mask;
               m_le[i]   = 1;
               for (int k = 0; k < 4; k++) m_sv[i][k] = 0;
            end else begin
               m_stage[i][a] = wd;
               m_sv[i][a]    = 1;
            end
         end else if (a == 2'd0) begin
            m_snap[i] = cvm;
            m_rd[i]   = cvm[15:0];
         end else begin
            val     = m_snap[i] >> (16 * int'(a));
            m_rd[i] = val[15:0];
         end
      end
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge and compare.
   task automatic cyc(bit r, bit rd, bit wr, logic [1:0] a, logic [15:0] wd, logic [47:0] cv);
      res           = r;
      rf_read_en    = rd;
      rf_write_en   = wr;
      rf_address    = a;
      rf_write_data = wd;
      cv48          = cv;
      cv40          = cv[39:0];
      model_step(0, r, rd, wr, a, wd, cv);
      model_step(1, r, rd, wr, a, wd, cv);
      @(posedge clk);
      #1;
      check("d48.rd",   64'(rd48),   64'(m_rd[0]));
      check("d48.cmp",  64'(cmp48),  64'(m_cmp[0]));
      check("d48.inv",  64'(inv48),  64'(m_inv[0]));
      check("d48.le",   64'(le48),   64'(m_le[0]));
      check("d48.load", 64'(load48), m_load[0]);
      check("d40.rd",   64'(rd40),   64'(m_rd[1]));
      check("d40.cmp",  64'(cmp40),  64'(m_cmp[1]));
      check("d40.inv",  64'(inv40),  64'(m_inv[1]));
      check("d40.le",   64'(le40),   64'(m_le[1]));
      check("d40.load", 64'(load40), m_load[1]);
      res         = 1'b0;
      rf_read_en  = 1'b0;
      rf_write_en = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  a;
      bit          rd;
      bit          wr;
      logic [15:0] wd;
      logic [47:0] cv;
      logic [15:0] e_rd;
      bit          e_cmp;
      bit          e_inv;
      bit          e_le;
      logic [47:0] e_load;
   } vec_t;

   vec_t tbl [14];

   initial begin
      tbl[0]  = '{2'd0, 1, 0, 16'h0000, 48'h0001_FFFF_FFFF, 16'hFFFF, 1, 0, 0, 48'h0};
      tbl[1]  = '{2'd1, 1, 0, 16'h0000, 48'h0002_0000_0000, 16'hFFFF, 1, 0, 0, 48'h0};
      tbl[2]  = '{2'd2, 1, 0, 16'h0000, 48'h0002_0000_0000, 16'h0001, 1, 0, 0, 48'h0};
      tbl[3]  = '{2'd0, 0, 0, 16'h0000, 48'h0002_0000_0000, 16'h0001, 0, 0, 0, 48'h0};
      tbl[4]  = '{2'd2, 0, 1, 16'h1234, 48'h0002_0000_0000, 16'h0001, 1, 0, 0, 48'h0};
      tbl[5]  = '{2'd1, 0, 1, 16'h5678, 48'h0002_0000_0000, 16'h0001, 1, 0, 0, 48'h0};
      tbl[6]  = '{2'd0, 0, 1, 16'h9ABC, 48'h0002_0000_0000, 16'h0001, 1, 0, 1, 48'h1234_5678_9ABC};
      tbl[7]  = '{2'd0, 0, 0, 16'h0000, 48'h0002_0000_0000, 16'h0001, 0, 0, 0, 48'h1234_5678_9ABC};
      tbl[8]  = '{2'd0, 0, 1, 16'h0001, 48'hAAAA_BBBB_CCCC, 16'h0001, 1, 0, 1, 48'hAAAA_BBBB_0001};
      tbl[9]  = '{2'd0, 0, 1, 16'h0002, 48'hAAAA_BBBB_CCCC, 16'h0001, 1, 0, 1, 48'hAAAA_BBBB_0002};
      tbl[10] = '{2'd3, 1, 0, 16'h0000, 48'hAAAA_BBBB_CCCC, 16'h0000, 1, 1, 0, 48'hAAAA_BBBB_0002};
      tbl[11] = '{2'd1, 1, 0, 16'h0000, 48'h5555_5555_5555, 16'hFFFF, 1, 0, 0, 48'hAAAA_BBBB_0002};
      tbl[12] = '{2'd0, 1, 1, 16'h0005, 48'h7777_8888_9999, 16'hFFFF, 1, 0, 1, 48'h7777_8888_0005};
      tbl[13] = '{2'd0, 0, 0, 16'h0000, 48'h7777_8888_9999, 16'hFFFF, 0, 0, 0, 48'h7777_8888_0005};

      // Reset state.
      @(negedge clk);
      cyc(1, 0, 0, 2'd0, 16'h0, 48'h0);
      check("rst.rd", 64'(rd48), 64'h0);
      check("rst.load", 64'(load48), 64'h0);

      // Directed vectors.
      for (int i = 0; i < 14; i++) begin
         cyc(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].cv);
         check($sformatf("vec%0d.rd", i),   64'(rd48),   64'(tbl[i].e_rd));
         check($sformatf("vec%0d.cmp", i),  64'(cmp48),  64'(tbl[i].e_cmp));
         check($sformatf("vec%0d.inv", i),  64'(inv48),  64'(tbl[i].e_inv));
         check($sformatf("vec%0d.le", i),   64'(le48),   64'(tbl[i].e_le));
         check($sformatf("vec%0d.load", i), 64'(load48), 64'(tbl[i].e_load));
      end

      // Reset mid-sequence discards staged words; a strobe in the reset cycle is ignored.
      cyc(0, 0, 1, 2'd2, 16'h1111, 48'h0);
      cyc(1, 1, 0, 2'd0, 16'h0, 48'h1234_5678_9ABC);
      check("midrst.rd", 64'(rd48), 64'h0);
      check("midrst.cmp", 64'(cmp48), 64'h0);
      check("midrst.inv", 64'(inv48), 64'h0);
      check("midrst.le", 64'(le48), 64'h0);
      check("midrst.load", 64'(load48), 64'h0);
      cyc(0, 0, 1, 2'd0, 16'h2222, 48'h0);
      check("midrst.commit", 64'(load48), 64'h0000_0000_2222);
      check("midrst.le2", 64'(le48), 64'h1);

      // Narrow counter: top word zero-filled, write bits above 40 discarded.
      cyc(0, 1, 0, 2'd0, 16'h0, 48'h00AB_CDEF_0123);
      check("narrow.rd0", 64'(rd40), 64'h0123);
      cyc(0, 1, 0, 2'd2, 16'h0, 48'h0);
      check("narrow.rd2", 64'(rd40), 64'h00AB);
      cyc(0, 0, 1, 2'd2, 16'hFFFF, 48'h0);
      cyc(0, 0, 1, 2'd0, 16'h0000, 48'h0);
      check("narrow.load40", 64'(load40), 64'hFF_0000_0000);
      check("narrow.load48", 64'(load48), 64'hFFFF_0000_0000);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         int unsigned op;
         logic [47:0] cv;
         op = $urandom_range(0, 3);
         cv = {16'($urandom), 32'($urandom)};
         cyc(($urandom_range(0, 39) == 0), (op == 1 || op == 3), (op == 2 || op == 3),
             2'($urandom_range(0, 3)), 16'($urandom), cv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
